// File: rtl/bytes_to_bits_stream_pkg.sv
// bytes_to_bits_stream_pkg
// Shared types and helpers for the byte-stream to bit-array assembler.
package bytes_to_bits_stream_pkg;

    // COLLECT gathers bytes, HOLD presents the finished frame.
    typedef enum logic [0:0] {B2B_COLLECT, B2B_HOLD} b2b_state_t;

    // Width of a counter that must be able to hold the full byte count of a frame.
    function automatic int b2b_cnt_w(input int bit_len);
        return $clog2(bit_len / 8 + 1);
    endfunction

endpackage

// File: rtl/bytes_to_bits_stream_if.sv
// bytes_to_bits_stream_if
// Byte-input / frame-output handshake bundle of the assembler.
// master = byte source + frame consumer side, slave = the assembler itself.
interface bytes_to_bits_stream_if
    import bytes_to_bits_stream_pkg::*;
#(
    parameter int BIT_LENGTH = 1024
);
    localparam int CNT_W = b2b_cnt_w(BIT_LENGTH);

    logic [7:0]            in_byte;
    logic                  in_valid;
    logic                  in_ready;
    logic [BIT_LENGTH-1:0] bit_array;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_W-1:0]      byte_count;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, bit_array, out_valid, byte_count
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, bit_array, out_valid, byte_count
    );

endinterface

// File: rtl/bytes_to_bits_stream.sv
// bytes_to_bits_stream
// Assembles a byte stream into a BIT_LENGTH-bit array in BytesToBits order
// (byte i bit j lands at bit 8*i+j) and hands the frame out with valid/ready.
// Optional build macro B2B_OVERRUN_FLAG_EN adds a sticky 'overrun' output that
// flags a source pushing bytes while the frame is being held.
module bytes_to_bits_stream
    import bytes_to_bits_stream_pkg::*;
#(
    parameter int BIT_LENGTH = 1024
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    bytes_to_bits_stream_if.slave bus
`ifdef B2B_OVERRUN_FLAG_EN
    ,
    output logic                 overrun
`endif
);

    localparam int BYTE_LENGTH = BIT_LENGTH / 8;
    localparam int CNT_W       = b2b_cnt_w(BIT_LENGTH);

    b2b_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_LENGTH-1:0] array_q;
    logic                  accept;

    // A byte is taken only while collecting and never on a flush edge.
    always_comb begin
        accept = bus.in_valid && (state_q == B2B_COLLECT) && !flush;
    end

    // Next-state and byte counter; flush overrides any transfer or release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = B2B_COLLECT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                B2B_COLLECT: begin
                    if (bus.in_valid) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(BYTE_LENGTH - 1)) begin
                            state_d = B2B_HOLD;
                        end
                    end
                end
                B2B_HOLD: begin
                    if (bus.out_ready) begin
                        state_d = B2B_COLLECT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = B2B_COLLECT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= B2B_COLLECT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte-lane write decoder: the lane selected by the counter takes the byte;
    // old contents are left in place until overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            array_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < BYTE_LENGTH; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    array_q[8*i +: 8] <= bus.in_byte;
                end
            end
        end
    end

`ifdef B2B_OVERRUN_FLAG_EN
    logic overrun_q;

    // Sticky flag for a source that ignores in_ready while the frame is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (flush) begin
            overrun_q <= 1'b0;
        end else if (bus.in_valid && (state_q == B2B_HOLD)) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

    assign bus.in_ready   = (state_q == B2B_COLLECT);
    assign bus.out_valid  = (state_q == B2B_HOLD);
    assign bus.bit_array  = array_q;
    assign bus.byte_count = cnt_q;

endmodule

// File: tb/tb_bytes_to_bits_stream.sv
// tb_bytes_to_bits_stream
// Scoreboard bench: a 32-bit instance for ordering/backpressure/flush cases and
// a 1024-bit instance for a long gapped stream. Expected frames are queued as
// stimulus is issued; per-instance monitors compare whenever out_valid is high.
module tb_bytes_to_bits_stream;

    logic clk = 1'b0;
    logic rst;
    logic flush32;
    logic flush1k;

    int checks = 0;
    int errors = 0;

    logic [31:0]   exp32[$];
    logic [1023:0] exp1k[$];

    bytes_to_bits_stream_if #(.BIT_LENGTH(32))   bus32();
    bytes_to_bits_stream_if #(.BIT_LENGTH(1024)) bus1k();

`ifdef B2B_OVERRUN_FLAG_EN
    logic ovr32;
    logic ovr1k;
`endif

    bytes_to_bits_stream #(.BIT_LENGTH(32)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush32),
        .bus   (bus32)
`ifdef B2B_OVERRUN_FLAG_EN
        ,
        .overrun (ovr32)
`endif
    );

    bytes_to_bits_stream #(.BIT_LENGTH(1024)) dut1k (
        .clk   (clk),
        .rst   (rst),
        .flush (flush1k),
        .bus   (bus1k)
`ifdef B2B_OVERRUN_FLAG_EN
        ,
        .overrun (ovr1k)
`endif
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, actual, expected);
        end
    endtask

    // Presents one byte from a negedge and returns at the negedge after it was taken.
    task automatic applyStimulus(input bit big, input logic [7:0] b);
        logic rdy;
        int   waited;
        waited = 0;
        if (big) begin
            bus1k.in_byte  = b;
            bus1k.in_valid = 1'b1;
        end else begin
            bus32.in_byte  = b;
            bus32.in_valid = 1'b1;
        end
        forever begin
            rdy = big ? bus1k.in_ready : bus32.in_ready;
            @(negedge clk);
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL byte_accept_timeout got none want accept of %0h", b);
                break;
            end
        end
    endtask

    // Monitor for the 32-bit instance: every held cycle must show the queued frame.
    always begin
        @(negedge clk);
        #2;
        if (!rst && bus32.out_valid) begin
            checks++;
            if (exp32.size() == 0) begin
                errors++;
                $display("[TB] FAIL frame32_unexpected got %h want no frame", bus32.bit_array);
            end else begin
                if (bus32.bit_array !== exp32[0] || bus32.byte_count !== 3'd4) begin
                    errors++;
                    $display("[TB] FAIL frame32 got %h/cnt %0d want %h/cnt 4",
                             bus32.bit_array, bus32.byte_count, exp32[0]);
                end
                if (bus32.out_ready && !flush32) void'(exp32.pop_front());
            end
        end
    end

    // Monitor for the 1024-bit instance; reports the first differing byte.
    always begin
        logic [1023:0] want;
        int            bad;
        @(negedge clk);
        #2;
        if (!rst && bus1k.out_valid) begin
            checks++;
            if (exp1k.size() == 0) begin
                errors++;
                $display("[TB] FAIL frame1k_unexpected got frame want no frame");
            end else begin
                want = exp1k[0];
                bad  = -1;
                for (int i = 0; i < 128; i++) begin
                    if (bad < 0 && bus1k.bit_array[8*i +: 8] !== want[8*i +: 8]) bad = i;
                end
                if (bad >= 0 || bus1k.byte_count !== 8'd128) begin
                    errors++;
                    if (bad < 0) bad = 0;
                    $display("[TB] FAIL frame1k byte %0d got %h want %h cnt %0d",
                             bad, bus1k.bit_array[8*bad +: 8], want[8*bad +: 8], bus1k.byte_count);
                end
                if (bus1k.out_ready && !flush1k) void'(exp1k.pop_front());
            end
        end
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed stimulus sequence.
    initial begin
        logic [7:0]    src[128];
        logic [1023:0] refBits;
        logic [7:0]    ordBytes[4];

        rst             = 1'b1;
        flush32         = 1'b0;
        flush1k         = 1'b0;
        bus32.in_byte   = 8'h00;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        bus1k.in_byte   = 8'h00;
        bus1k.in_valid  = 1'b0;
        bus1k.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        checkOutput("rst_count", 64'(bus32.byte_count), 64'd0);
        checkOutput("rst_array", 64'(bus32.bit_array), 64'd0);
        checkOutput("rst_in_ready_1k", 64'(bus1k.in_ready), 64'd1);
`ifdef B2B_OVERRUN_FLAG_EN
        checkOutput("rst_overrun", 64'(ovr32), 64'd0);
`endif

        // Asynchronous reset in the middle of a partial frame.
        applyStimulus(1'b0, 8'h5A);
        applyStimulus(1'b0, 8'hC3);
        bus32.in_valid = 1'b0;
        checkOutput("partial_count", 64'(bus32.byte_count), 64'd2);
        checkOutput("partial_array", 64'(bus32.bit_array), 64'h0000C35A);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_rst_count", 64'(bus32.byte_count), 64'd0);
        checkOutput("async_rst_array", 64'(bus32.bit_array), 64'd0);
        checkOutput("async_rst_in_ready", 64'(bus32.in_ready), 64'd1);
        checkOutput("async_rst_out_valid", 64'(bus32.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ordering: LSB-first bytes, one-cycle out_valid with immediate consumer.
        ordBytes = '{8'h01, 8'h80, 8'hA5, 8'hFF};
        exp32.push_back(32'hFFA58001);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, ordBytes[i]);
        bus32.in_valid = 1'b0;
        checkOutput("order_out_valid", 64'(bus32.out_valid), 64'd1);
        checkOutput("order_bit0", 64'(bus32.bit_array[0]), 64'd1);
        checkOutput("order_bit15", 64'(bus32.bit_array[15]), 64'd1);
        checkOutput("order_in_ready_hold", 64'(bus32.in_ready), 64'd0);
        @(negedge clk);
        checkOutput("order_out_valid_drop", 64'(bus32.out_valid), 64'd0);
        checkOutput("order_in_ready_back", 64'(bus32.in_ready), 64'd1);
        checkOutput("order_count_clear", 64'(bus32.byte_count), 64'd0);

        // Backpressure: frame held five cycles while the source keeps pushing.
        bus32.out_ready = 1'b0;
        exp32.push_back(32'h40302010);
        applyStimulus(1'b0, 8'h10);
        applyStimulus(1'b0, 8'h20);
        applyStimulus(1'b0, 8'h30);
        applyStimulus(1'b0, 8'h40);
        bus32.in_byte = 8'h55;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_in_ready", 64'(bus32.in_ready), 64'd0);
            checkOutput("bp_count", 64'(bus32.byte_count), 64'd4);
            @(negedge clk);
        end
        bus32.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_count", 64'(bus32.byte_count), 64'd0);
        checkOutput("bp_release_in_ready", 64'(bus32.in_ready), 64'd1);
        checkOutput("bp_release_out_valid", 64'(bus32.out_valid), 64'd0);
        bus32.in_valid = 1'b0;
`ifdef B2B_OVERRUN_FLAG_EN
        checkOutput("overrun_set", 64'(ovr32), 64'd1);
`endif

        // Flush during collection drops the partial frame and the coincident byte.
        applyStimulus(1'b0, 8'hAA);
        applyStimulus(1'b0, 8'hBB);
        checkOutput("flush_pre_count", 64'(bus32.byte_count), 64'd2);
`ifdef B2B_OVERRUN_FLAG_EN
        checkOutput("overrun_sticky", 64'(ovr32), 64'd1);
`endif
        bus32.in_byte = 8'hCC;
        flush32       = 1'b1;
        @(negedge clk);
        flush32        = 1'b0;
        bus32.in_valid = 1'b0;
        checkOutput("flush_count", 64'(bus32.byte_count), 64'd0);
        checkOutput("flush_in_ready", 64'(bus32.in_ready), 64'd1);
`ifdef B2B_OVERRUN_FLAG_EN
        checkOutput("overrun_flushed", 64'(ovr32), 64'd0);
`endif
        exp32.push_back(32'h44332211);
        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h22);
        applyStimulus(1'b0, 8'h33);
        applyStimulus(1'b0, 8'h44);
        bus32.in_valid = 1'b0;
        checkOutput("post_flush_out_valid", 64'(bus32.out_valid), 64'd1);
        @(negedge clk);

        // Flush while holding wins over a simultaneous output handshake.
        bus32.out_ready = 1'b0;
        exp32.push_back(32'h04030201);
        applyStimulus(1'b0, 8'h01);
        applyStimulus(1'b0, 8'h02);
        applyStimulus(1'b0, 8'h03);
        applyStimulus(1'b0, 8'h04);
        bus32.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("hold_flush_pre_valid", 64'(bus32.out_valid), 64'd1);
        flush32         = 1'b1;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        checkOutput("hold_flush_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("hold_flush_count", 64'(bus32.byte_count), 64'd0);
        checkOutput("hold_flush_in_ready", 64'(bus32.in_ready), 64'd1);
        void'(exp32.pop_front());
        @(negedge clk);
        checkOutput("hold_flush_no_frame", 64'(bus32.out_valid), 64'd0);

        // Long gapped stream into the 1024-bit instance against a bitwise reference.
        for (int i = 0; i < 128; i++) src[i] = 8'((i * 37 + 91) % 256);
        refBits = '0;
        for (int i = 0; i < 128; i++) begin
            for (int j = 0; j < 8; j++) refBits[8*i + j] = src[i][j];
        end
        exp1k.push_back(refBits);
        for (int i = 0; i < 128; i++) begin
            if (i % 3 != 0) begin
                bus1k.in_valid = 1'b0;
                repeat (i % 3) @(negedge clk);
            end
            if (i == 127) begin
                checkOutput("gap_pre_last_count", 64'(bus1k.byte_count), 64'd127);
                checkOutput("gap_pre_last_valid", 64'(bus1k.out_valid), 64'd0);
            end
            applyStimulus(1'b1, src[i]);
        end
        bus1k.in_valid = 1'b0;
        checkOutput("gap_out_valid", 64'(bus1k.out_valid), 64'd1);
        checkOutput("gap_count", 64'(bus1k.byte_count), 64'd128);
        @(negedge clk);
        checkOutput("gap_out_valid_drop", 64'(bus1k.out_valid), 64'd0);

        repeat (3) @(negedge clk);
        checkOutput("queue32_drained", 64'(exp32.size()), 64'd0);
        checkOutput("queue1k_drained", 64'(exp1k.size()), 64'd0);
`ifdef B2B_OVERRUN_FLAG_EN
        checkOutput("overrun_final", 64'(ovr32), 64'd0);
        checkOutput("overrun_1k", 64'(ovr1k), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bytes_to_bits_stream.md
Name: bytes_to_bits_stream

Overview:
- Sequential counterpart of the combinational bits-to-bytes path.
- Accepts a byte stream one byte per handshake and assembles it into a BIT_LENGTH-bit array using Kyber BytesToBits ordering.
- Presents the completed array with a valid/ready handshake.
- Sits between byte-oriented sources (SHAKE/seed/ciphertext buffers) and bit-oriented consumers (decode/decompress stages).

Parameters:
- BIT_LENGTH, 1024, output array width in bits; must be a multiple of 8 and at least 8.
- BYTE_LENGTH, BIT_LENGTH/8, number of bytes per frame; derived, not overridden.
- CNT_W, $clog2(BYTE_LENGTH+1), width of the byte counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort: discards the partial frame and any held frame.
- in_byte  input  8  incoming byte.
- in_valid  input  1  in_byte is valid this cycle.
- in_ready  output  1  block accepts in_byte this cycle.
- bit_array  output  BIT_LENGTH  assembled bits; bit 8*i+j = byte i, bit j.
- out_valid  output  1  bit_array holds a complete frame.
- out_ready  input  1  consumer takes the frame.
- byte_count  output  CNT_W  bytes accepted in the current frame.

Behaviour:
- Reset (async, rst=1):
  - state=COLLECT, byte_count=0, bit_array=0, out_valid=0, in_ready=1.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Byte acceptance: a transfer occurs on a clk edge where in_valid&in_ready.
  - in_byte is written to bit_array[8*byte_count +: 8], with byte i bit j landing at bit 8*i+j (LSB-first).
  - byte_count then increments.
- COLLECT->HOLD: on the transfer with byte_count==BYTE_LENGTH-1.
  - The final byte is written, byte_count becomes BYTE_LENGTH and out_valid rises the next cycle.
  - Latency from last input byte to out_valid is 1 cycle.
- HOLD: bit_array and byte_count stay stable while out_valid&!out_ready; in_valid is ignored (in_ready=0).
- HOLD->COLLECT: on out_valid&out_ready.
  - byte_count clears to 0 and out_valid falls next cycle.
  - bit_array keeps its old contents until overwritten byte by byte; consumers must not sample it while out_valid=0.
  - in_ready=1 the cycle after release. There is no same-cycle pass-through, so throughput is BYTE_LENGTH+1 cycles per frame.
- flush=1 in any state: next edge forces COLLECT, byte_count=0, out_valid=0.
  - flush has priority over a simultaneous byte transfer or output handshake; that byte is dropped and the frame is not delivered.
  - bit_array is not cleared.
- byte_count never exceeds BYTE_LENGTH and never wraps.
- in_valid with in_ready=0 is a legal stall; the source must hold in_byte.
- Reset mid-frame discards everything immediately (asynchronous).

Optional Feature:
- Macro: B2B_OVERRUN_FLAG_EN.
- When defined:
  - Adds output port overrun (1 bit, reset 0).
  - overrun is set sticky when in_valid=1 while state=HOLD (a source that does not honour in_ready).
  - Cleared only by rst or flush.
- When undefined: the port does not exist and no related logic is present.

Decomposition:
- Shared package kyber_pkg gains:
  - typedef enum logic [0:0] {B2B_COLLECT, B2B_HOLD} b2b_state_t;
  - function b2b_cnt_w(bit_len) returning $clog2(bit_len/8+1).
- No sub-module needed. The byte-lane write decoder is a single always_ff indexed part-select.
- An optional wrapper bytes_to_bits_stream_gated may AND the outputs with an enable, matching the existing gated-wrapper style.

Test Plan:
- Reset/idle: rst pulse mid-cycle with BIT_LENGTH=32 -> immediately out_valid=0, in_ready=1, byte_count=0, bit_array=0.
- Ordering: BIT_LENGTH=32, stream 0x01,0x80,0xA5,0xFF with out_ready=1 -> out_valid for exactly 1 cycle, bit_array=32'hFFA58001, bit0=1, bit15=1.
- Backpressure: complete frame with out_ready=0 for 5 cycles, in_valid held 1 -> in_ready=0, bit_array stable for 5 cycles, no byte accepted; out_ready=1 -> release, next frame starts at byte_count=0.
- Flush: 2 of 4 bytes accepted, flush=1 coincident with a third in_valid -> byte_count=0, that byte not counted; then 4 new bytes -> bit_array equals only the new bytes.
- Gapped input: bytes with random in_valid gaps, BIT_LENGTH=1024 -> out_valid exactly 1 cycle after the 128th accepted byte, contents match a BytesToBits reference model.
- B2B_OVERRUN_FLAG_EN: in_valid=1 during HOLD -> overrun=1, sticky through release and the next frame; flush -> overrun=0.
